stepdown_priority_resolver: RTL and testbench
=============================================

# stepdown_priority_resolver

Synchronous controller for the two-input asynchronous priority latch in the stepdown loop control. It drives the latch's arm line (`tstate`), resynchronises the two latched grant outputs, and decodes which request won, lost, timed out, or produced an illegal double grant. It presents the decision to loop control over a valid/ready handshake. It then clears and re-arms the latch for the next comparison.

## Interface
- `SYNC_STAGES`, 2: flops per grant synchroniser; legal range 2..4.
- `CLEAR_CYCLES`, 4: cycles `tstate` is held low before arming, so both latches reset; must be ≥1.
- `TIMEOUT`, 255: cycles in ARMED with no synced grant before reporting a timeout; must be ≥1.
- `clk`  in  1  block clock.
- `rstb`  in  1  synchronous active-low reset.
- `start`  in  1  single-cycle request to begin a comparison; ignored unless in IDLE.
- `auto_rearm`  in  1  sampled at handshake completion; 1 goes to CLEAR, 0 goes to IDLE.
- `grant0`  in  1  latch output o0, asynchronous to `clk`.
- `grant1`  in  1  latch output o1, asynchronous to `clk`.
- `tstate`  out  1  arm line to the latch (Tstate); registered.
- `busy`  out  1  high in every state except IDLE.
- `res_valid`  out  1  result available.
- `res_code`  out  2  00 timeout, 01 grant0 first, 10 grant1 first, 11 error (both grants, or stuck grant).
- `res_ready`  in  1  consumer accepts the result.

## Operation
- FSM states: IDLE, CLEAR, ARMED, SETTLE, REPORT.
- IDLE
  - `tstate`=0 and `busy`=0.
  - `start`=1 → CLEAR.
- CLEAR
  - `tstate`=0; a counter runs for `CLEAR_CYCLES` cycles.
  - On exit, if either synced grant is still 1, the latch failed to reset: `res_code`=11 and go to REPORT.
  - Otherwise go to ARMED with `tstate`=1.
- ARMED
  - `tstate`=1; the timeout counter increments each cycle.
  - Any synced grant = 1 → SETTLE.
  - Counter reaching `TIMEOUT`-1 with no grant → `res_code`=00 and go to REPORT.
  - If a grant and the timeout occur in the same cycle, the grant wins.
- SETTLE
  - Lasts exactly one cycle, to catch a late second grant that crossed the synchroniser.
  - Decode: only s0 → 01; only s1 → 10; both → 11.
  - Then REPORT.
- REPORT
  - `res_valid`=1; `res_code` is held stable and `tstate` stays at its current value.
  - When `res_valid` & `res_ready` are both high, drop `res_valid` and go to CLEAR or IDLE according to `auto_rearm`.
- Grants seen while `tstate`=0 are ignored, except for the stuck-grant check at the end of CLEAR.
- Reset
  - Reset values: `tstate`=0, `busy`=0, `res_valid`=0, `res_code`=00; FSM in IDLE; counters and synchronisers cleared.
  - Reset asserted mid-operation takes effect at the next edge, including from ARMED or REPORT. No result is emitted.

## Timing
- `start` seen at edge n → CLEAR from n+1.
- `tstate` rises at edge n+1+`CLEAR_CYCLES`.
- A grant rising before edge k is visible as a synced grant after edge k+`SYNC_STAGES`-1.
- From that point, SETTLE occupies one cycle and `res_valid` rises one edge later. Worst-case latency from grant to `res_valid` is therefore `SYNC_STAGES`+2 cycles.
- Handshake completes on the edge where `res_valid` & `res_ready` are both 1.
- When re-arming, `tstate` falls on that same edge.
- `res_ready` may be tied high; no combinational path runs from `res_ready` to any output.

## Configuration
- `STEPDOWN_RESOLVER_STATS_EN` defined:
  - Adds outputs `cnt_win0`, `cnt_win1`, `cnt_timeout`, `cnt_error` (16 bits each).
  - Each counter increments on handshake completion for its `res_code`.
  - Counters saturate at 0xFFFF and clear on reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Package `stepdown_pkg` holds:
  - the `res_code` enum (`RES_TIMEOUT`, `RES_WIN0`, `RES_WIN1`, `RES_ERROR`);
  - the FSM state enum;
  - the counter width constant (16).
- Sub-module `stepdown_sync`: a parameterised `SYNC_STAGES`-deep synchroniser, reset to 0 by `rstb`. It is instantiated once per grant.

## Test plan
- `CLEAR_CYCLES`=4, `SYNC_STAGES`=2: `start`, then raise `grant0` 3 cycles after `tstate` rises, with `res_ready`=1.
  - Required: `tstate` rises 5 cycles after `start`; `res_valid` rises within 4 cycles of the grant, with `res_code`=01.
- Raise `grant1`, then `grant0` one cycle later.
  - Required: `res_code`=10 if the second grant lands after SETTLE, 11 if it lands within the SETTLE window.
- `TIMEOUT`=10, no grants.
  - Required: `res_code`=00 exactly 10 cycles after `tstate` rises.
- `grant0` held at 1 throughout CLEAR.
  - Required: `res_code`=11 with `tstate` never asserted.
- `res_ready`=0 for 20 cycles in REPORT.
  - Required: `res_valid` and `res_code` stay stable.
  - On accept with `auto_rearm`=1: `tstate` falls at that edge and a new CLEAR starts.
- `rstb`=0 for one cycle while in ARMED.
  - Required: all outputs at reset values on the next edge; `start` ignored until `rstb`=1.

Source files
------------

// File: rtl/stepdown_pkg.sv
// Shared types for the stepdown priority resolver: result codes, FSM states and
// the width of the optional statistics counters.
package stepdown_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    RES_TIMEOUT = 2'b00,
    RES_WIN0    = 2'b01,
    RES_WIN1    = 2'b10,
    RES_ERROR   = 2'b11
  } res_code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ARMED,
    ST_SETTLE,
    ST_REPORT
  } state_t;

endpackage

// File: rtl/stepdown_sync.sv
// Multi-flop synchroniser bringing one asynchronous latch grant into the clk
// domain; cleared to 0 by the synchronous active-low reset.
module stepdown_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstb,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (!rstb) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], d};
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/stepdown_priority_resolver.sv
// Arms the asynchronous two-input priority latch, resolves which grant came
// first and reports it over valid/ready. Optional per-result statistics
// counters are built when STEPDOWN_RESOLVER_STATS_EN is defined.
module stepdown_priority_resolver
  import stepdown_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int CLEAR_CYCLES = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic             auto_rearm,
  input  logic             grant0,
  input  logic             grant1,
  input  logic             res_ready,
  output logic             tstate,
  output logic             busy,
  output logic             res_valid,
  output logic [1:0]       res_code
`ifdef STEPDOWN_RESOLVER_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt_win0,
  output logic [CNT_W-1:0] cnt_win1,
  output logic [CNT_W-1:0] cnt_timeout,
  output logic [CNT_W-1:0] cnt_error
`endif
);

  // One shared counter serves both the CLEAR hold and the ARMED timeout.
  localparam int CNT_MAX = (TIMEOUT > CLEAR_CYCLES) ? TIMEOUT : CLEAR_CYCLES;
  localparam int TW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic      s0, s1;
  state_t    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic      tstate_q, tstate_d;
  res_code_t code_q, code_d;

  stepdown_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync0 (
    .clk (clk), .rstb(rstb), .d(grant0), .q(s0)
  );
  stepdown_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
    .clk (clk), .rstb(rstb), .d(grant1), .q(s1)
  );

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      tstate_q <= 1'b0;
      code_q   <= RES_TIMEOUT;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tstate_q <= tstate_d;
      code_q   <= code_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tstate_d = tstate_q;
    code_d   = code_q;
    unique case (state_q)
      ST_IDLE: begin
        tstate_d = 1'b0;
        if (start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        tstate_d = 1'b0;
        if (cnt_q == TW'(CLEAR_CYCLES - 1)) begin
          cnt_d = '0;
          // A grant surviving the whole clear means the latch did not reset.
          if (s0 || s1) begin
            code_d  = RES_ERROR;
            state_d = ST_REPORT;
          end else begin
            tstate_d = 1'b1;
            state_d  = ST_ARMED;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_ARMED: begin
        if (s0 || s1) begin
          state_d = ST_SETTLE;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          code_d  = RES_TIMEOUT;
          state_d = ST_REPORT;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_SETTLE: begin
        state_d = ST_REPORT;
        unique case ({s1, s0})
          2'b01:   code_d = RES_WIN0;
          2'b10:   code_d = RES_WIN1;
          default: code_d = RES_ERROR;
        endcase
      end
      ST_REPORT: begin
        if (res_ready) begin
          tstate_d = 1'b0;
          cnt_d    = '0;
          state_d  = auto_rearm ? ST_CLEAR : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tstate    = tstate_q;
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_REPORT);
  assign res_code  = code_q;

`ifdef STEPDOWN_RESOLVER_STATS_EN
  logic [CNT_W-1:0] stat_q [4];

  // NOTE: this small counter array is reset element by element because the
  // counts must read zero after reset; plain storage arrays are left unreset.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      for (int i = 0; i < 4; i++) stat_q[i] <= '0;
    end else if (state_q == ST_REPORT && res_ready && stat_q[code_q] != '1) begin
      stat_q[code_q] <= stat_q[code_q] + CNT_W'(1);
    end
  end

  assign cnt_timeout = stat_q[0];
  assign cnt_win0    = stat_q[1];
  assign cnt_win1    = stat_q[2];
  assign cnt_error   = stat_q[3];
`endif

endmodule

// File: tb/tb_stepdown_priority_resolver.sv
// Directed bench for stepdown_priority_resolver: a table of grant timings with
// expected codes and latencies, plus sequences for stuck grant, backpressure
// with re-arm, and reset while armed.
module tb_stepdown_priority_resolver;

  localparam int SYNC_STAGES  = 2;
  localparam int CLEAR_CYCLES = 4;
  localparam int TIMEOUT      = 10;
  localparam int NEVER        = 255;
  localparam int NV           = 8;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       start = 1'b0;
  logic       auto_rearm = 1'b0;
  logic       grant0 = 1'b0;
  logic       grant1 = 1'b0;
  logic       res_ready = 1'b1;
  logic       tstate, busy, res_valid;
  logic [1:0] res_code;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         g0_at;
    int         g1_at;
    logic [1:0] exp_code;
    int         exp_lat;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  stepdown_priority_resolver #(
    .SYNC_STAGES (SYNC_STAGES),
    .CLEAR_CYCLES(CLEAR_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .start     (start),
    .auto_rearm(auto_rearm),
    .grant0    (grant0),
    .grant1    (grant1),
    .res_ready (res_ready),
    .tstate    (tstate),
    .busy      (busy),
    .res_valid (res_valid),
    .res_code  (res_code)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Pulses start and returns the number of edges until tstate is seen high.
  task automatic run_start(output int t);
    start = 1'b1;
    t = 0;
    do begin
      tick();
      start = 1'b0;
      t++;
    end while (!tstate && t < 40);
  endtask

  task automatic wait_valid(output int t);
    t = 0;
    while (!res_valid && t < 40) begin
      tick();
      t++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int t;
    int bad;
    logic saw_t;

    // grant timings are counted in edges after tstate rises
    vecs[0] = '{3,     NEVER, 2'b01, 7};
    vecs[1] = '{NEVER, 0,     2'b10, 4};
    vecs[2] = '{3,     2,     2'b11, 6};
    vecs[3] = '{4,     2,     2'b10, 6};
    vecs[4] = '{1,     1,     2'b11, 5};
    vecs[5] = '{NEVER, NEVER, 2'b00, 10};
    vecs[6] = '{7,     NEVER, 2'b01, 11};
    vecs[7] = '{8,     NEVER, 2'b00, 10};

    // reset state
    repeat (2) tick();
    check("rst_tstate", 32'(tstate), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(res_valid), 0);
    check("rst_code", 32'(res_code), 0);
    rstb = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      run_start(t);
      check($sformatf("v%0d_arm_delay", i), t, CLEAR_CYCLES + 1);
      t = 0;
      while (!res_valid && t < 40) begin
        if (t == vecs[i].g0_at) grant0 = 1'b1;
        if (t == vecs[i].g1_at) grant1 = 1'b1;
        tick();
        t++;
      end
      check($sformatf("v%0d_latency", i), t, vecs[i].exp_lat);
      check($sformatf("v%0d_code", i), 32'(res_code), 32'(vecs[i].exp_code));
      check($sformatf("v%0d_tstate_in_report", i), 32'(tstate), 1);
      tick();
      check($sformatf("v%0d_valid_dropped", i), 32'(res_valid), 0);
      check($sformatf("v%0d_idle", i), 32'(busy), 0);
      check($sformatf("v%0d_tstate_low", i), 32'(tstate), 0);
      grant0 = 1'b0;
      grant1 = 1'b0;
      repeat (3) tick();
    end

    // stuck grant across CLEAR
    grant0 = 1'b1;
    repeat (3) tick();
    start = 1'b1;
    t = 0;
    saw_t = 1'b0;
    while (!res_valid && t < 40) begin
      tick();
      start = 1'b0;
      t++;
      if (tstate) saw_t = 1'b1;
    end
    check("stuck_latency", t, CLEAR_CYCLES + 1);
    check("stuck_code", 32'(res_code), 3);
    check("stuck_tstate_never", 32'(saw_t), 0);
    tick();
    grant0 = 1'b0;
    repeat (3) tick();
    check("stuck_idle", 32'(busy), 0);

    // backpressure in REPORT, then accept with re-arm
    res_ready  = 1'b0;
    auto_rearm = 1'b1;
    run_start(t);
    check("bp_arm_delay", t, CLEAR_CYCLES + 1);
    grant0 = 1'b1;
    wait_valid(t);
    check("bp_latency", t, SYNC_STAGES + 2);
    grant0 = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (res_valid !== 1'b1 || res_code !== 2'b01 || tstate !== 1'b1) bad++;
    end
    check("bp_hold_unstable_cycles", bad, 0);
    res_ready = 1'b1;
    tick();
    check("rearm_tstate_fell", 32'(tstate), 0);
    check("rearm_valid_dropped", 32'(res_valid), 0);
    check("rearm_busy", 32'(busy), 1);
    t = 0;
    while (!tstate && t < 40) begin
      tick();
      t++;
    end
    check("rearm_clear_len", t, CLEAR_CYCLES);

    // reset while ARMED, with start held during reset
    auto_rearm = 1'b0;
    tick();
    rstb  = 1'b0;
    start = 1'b1;
    tick();
    check("armrst_tstate", 32'(tstate), 0);
    check("armrst_busy", 32'(busy), 0);
    check("armrst_valid", 32'(res_valid), 0);
    check("armrst_code", 32'(res_code), 0);
    tick();
    check("armrst_start_ignored", 32'(busy), 0);
    rstb  = 1'b1;
    start = 1'b0;
    tick();
    check("post_rst_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
